pipelined_decode_ctrl: RTL
==========================

// Module: pipelined_decode_ctrl
// PURPOSE
//  Registered RV32 decode/control stage between IF and EX. Decodes R, I-ALU, LW, SW, BEQ/BNE into
//  ALU op and datapath controls. Captures them in a one-entry output register with valid/ready handshake.
//  Detects load-use hazards against the instruction in EX and stalls. Supports flush, and counts stall cycles.
// PARAMETERS
//  ALUOP_W   4   width of alu_op (>=4; upper bits zero)
//  EN_SHIFT  1   1: SLL/SRL/SRA(+I forms) legal; 0: they decode as illegal
//  CNT_W     16  width of stall_cnt (saturating)
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        async active-low reset
//  in_valid     in   1        instr valid from IF
//  in_ready     out  1        stage accepts instr this cycle
//  instr        in   32       instruction word
//  flush        in   1        kill held and incoming instr (branch taken)
//  ex_mem_read  in   1        instr currently in EX is a load
//  ex_rd        in   5        dest reg of instr in EX
//  out_valid    out  1        decoded bundle valid
//  out_ready    in   1        EX accepts bundle
//  reg_write    out  1        write rd
//  alu_op       out  ALUOP_W  AND=0 OR=1 ADD=2 XOR=3 SUB=6 SLT=7 SLL=8 SRL=9 SRA=10
//  alu_src_imm  out  1        operand B = immediate
//  mem_read     out  1        LW
//  mem_write    out  1        SW
//  branch       out  1        conditional branch
//  branch_ne    out  1        1=BNE, 0=BEQ (valid with branch)
//  illegal      out  1        unsupported encoding
//  rd/rs1/rs2   out  5 each   register fields, rd forced 0 when reg_write=0
//  stall_cnt    out  CNT_W    cycles with in_valid && hazard, saturating at all-ones
// BEHAVIOUR
//  Reset: every output register 0 (out_valid=0, alu_op=0, stall_cnt=0).
//  Decode key {funct7[5],funct3}:
//   - R (0110011): 0000 ADD, 1000 SUB, 0111 AND, 0110 OR, 0100 XOR, 0010 SLT, 0001 SLL, 0101 SRL, 1101 SRA.
//   - I-ALU (0010011): same funct3 map. funct7[5] ignored except SRAI (funct3 101, funct7[5]=1); no SUBI.
//   - LW (0000011,f3=010): ADD, imm, mem_read, reg_write.
//   - SW (0100011,f3=010): ADD, imm, mem_write.
//   - BEQ/BNE (1100011,f3=000/001): SUB, branch.
//   - Anything else: illegal=1, all controls 0, alu_op=0. Never X.
//  rd==0: reg_write forced 0. illegal still propagates with out_valid.
//  Source use: R, SW, B use rs1+rs2; I-ALU, LW use rs1 only.
//  hazard = in_valid & ex_mem_read & (ex_rd!=0) & (used rs==ex_rd).
//  in_ready = (!out_valid | out_ready) & !hazard & !flush.
//  Accept (in_valid & in_ready): bundle registered next edge, out_valid=1. Latency 1 cycle.
//  Hold: out_valid & !out_ready -> bundle stable, in_ready=0.
//  Drain without refill: out_valid clears on out_ready.
//  flush: out_valid<=0 next edge, no accept that cycle; flush wins over all.
//  Counter: stall_cnt += 1 each cycle with hazard & !flush, sticks at 2^CNT_W-1.
//  Reset mid-operation: async clear of all state; first accept possible on first edge after release.
// TESTING
//  1. Reset, then ADD x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle out_valid=1, alu_op=2, reg_write=1, rd=3.
//  2. SUB/SRA/SRAI/LW/SW/BNE sweep -> alu_op 6/10/10/2/2/6; mem_read, mem_write, branch_ne set exactly as table.
//  3. ex_mem_read=1, ex_rd=1, incoming ADD x3,x1,x2 for 3 cycles -> in_ready=0, stall_cnt=3; then ex_mem_read=0 -> accepted.
//  4. out_ready=0 with bundle held, new instr offered -> in_ready=0, outputs unchanged; out_ready=1 -> next accepted, no loss/duplication.
//  5. flush with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, instr not captured; ADDI x0,x0,0 -> reg_write=0; 0xFFFFFFFF -> illegal=1.
//  6. Assert rst_n=0 mid-stream -> outputs/stall_cnt 0 immediately; CNT_W=2 with 5 stall cycles -> stall_cnt=3.

Source files
------------

// File: rtl/pipelined_decode_ctrl_if.sv
// Decode-stage bus: IF-side handshake, EX hazard inputs, and the
// registered control bundle handed to EX.
interface pipelined_decode_ctrl_if #(
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        instr;
    logic               flush;
    logic               ex_mem_read;
    logic [4:0]         ex_rd;
    logic               out_valid;
    logic               out_ready;
    logic               reg_write;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src_imm;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic               branch_ne;
    logic               illegal;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [CNT_W-1:0]   stall_cnt;

    // upstream / environment view
    modport master (
        output in_valid, instr, flush, ex_mem_read, ex_rd, out_ready,
        input  in_ready, out_valid, reg_write, alu_op, alu_src_imm, mem_read,
               mem_write, branch, branch_ne, illegal, rd, rs1, rs2, stall_cnt
    );

    // decode stage view
    modport slave (
        input  in_valid, instr, flush, ex_mem_read, ex_rd, out_ready,
        output in_ready, out_valid, reg_write, alu_op, alu_src_imm, mem_read,
               mem_write, branch, branch_ne, illegal, rd, rs1, rs2, stall_cnt
    );
endinterface

// File: rtl/pipelined_decode_ctrl.sv
// RV32 decode/control stage: combinational decode of the offered word,
// load-use hazard stall, one-entry registered output bundle, stall counter.
module pipelined_decode_ctrl #(
    parameter int ALUOP_W  = 4,
    parameter bit EN_SHIFT = 1'b1,
    parameter int CNT_W    = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    pipelined_decode_ctrl_if.slave bus
);
    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_LW = 7'b0000011;
    localparam logic [6:0] OPC_SW = 7'b0100011;
    localparam logic [6:0] OPC_B  = 7'b1100011;

    localparam logic [3:0] OP_AND = 4'd0, OP_OR  = 4'd1, OP_ADD = 4'd2, OP_XOR = 4'd3,
                           OP_SUB = 4'd6, OP_SLT = 4'd7, OP_SLL = 4'd8, OP_SRL = 4'd9,
                           OP_SRA = 4'd10;

    logic [6:0] opc;
    logic [2:0] f3;
    logic       f7b;
    logic [4:0] rd_f, rs1_f, rs2_f;

    assign opc   = bus.instr[6:0];
    assign rd_f  = bus.instr[11:7];
    assign f3    = bus.instr[14:12];
    assign rs1_f = bus.instr[19:15];
    assign rs2_f = bus.instr[24:20];
    assign f7b   = bus.instr[30];

    logic       legal, shift, rw_base;
    logic [3:0] op_d;
    logic       rw_d, imm_d, mr_d, mw_d, br_d, bne_d, use1_d, use2_d;
    logic       hazard, accept;

    // Decode the offered word; illegal encodings collapse to all-zero controls.
    always_comb begin
        legal   = 1'b0;
        shift   = 1'b0;
        rw_base = 1'b0;
        op_d    = OP_AND;
        imm_d   = 1'b0;
        mr_d    = 1'b0;
        mw_d    = 1'b0;
        br_d    = 1'b0;
        bne_d   = 1'b0;
        use1_d  = 1'b0;
        use2_d  = 1'b0;
        case (opc)
            OPC_R: begin
                legal = 1'b1; rw_base = 1'b1; use1_d = 1'b1; use2_d = 1'b1;
                case ({f7b, f3})
                    4'b0000: op_d = OP_ADD;
                    4'b1000: op_d = OP_SUB;
                    4'b0111: op_d = OP_AND;
                    4'b0110: op_d = OP_OR;
                    4'b0100: op_d = OP_XOR;
                    4'b0010: op_d = OP_SLT;
                    4'b0001: begin op_d = OP_SLL; shift = 1'b1; end
                    4'b0101: begin op_d = OP_SRL; shift = 1'b1; end
                    4'b1101: begin op_d = OP_SRA; shift = 1'b1; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_I: begin
                // funct7[5] only matters to pick SRAI over SRLI
                legal = 1'b1; rw_base = 1'b1; imm_d = 1'b1; use1_d = 1'b1;
                case (f3)
                    3'b000:  op_d = OP_ADD;
                    3'b111:  op_d = OP_AND;
                    3'b110:  op_d = OP_OR;
                    3'b100:  op_d = OP_XOR;
                    3'b010:  op_d = OP_SLT;
                    3'b001:  begin op_d = OP_SLL; shift = 1'b1; end
                    3'b101:  begin op_d = f7b ? OP_SRA : OP_SRL; shift = 1'b1; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LW: if (f3 == 3'b010) begin
                legal = 1'b1; op_d = OP_ADD; imm_d = 1'b1; mr_d = 1'b1;
                rw_base = 1'b1; use1_d = 1'b1;
            end
            OPC_SW: if (f3 == 3'b010) begin
                legal = 1'b1; op_d = OP_ADD; imm_d = 1'b1; mw_d = 1'b1;
                use1_d = 1'b1; use2_d = 1'b1;
            end
            OPC_B: if (f3 == 3'b000 || f3 == 3'b001) begin
                legal = 1'b1; op_d = OP_SUB; br_d = 1'b1; bne_d = f3[0];
                use1_d = 1'b1; use2_d = 1'b1;
            end
            default: ;
        endcase
        if (shift && !EN_SHIFT) legal = 1'b0;
        if (!legal) begin
            rw_base = 1'b0; op_d = OP_AND; imm_d = 1'b0; mr_d = 1'b0; mw_d = 1'b0;
            br_d = 1'b0; bne_d = 1'b0; use1_d = 1'b0; use2_d = 1'b0;
        end
        rw_d = rw_base && (rd_f != 5'd0);
    end

    // Load-use hazard only against source registers the instruction really reads.
    assign hazard = bus.in_valid && bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                    ((use1_d && (rs1_f == bus.ex_rd)) || (use2_d && (rs2_f == bus.ex_rd)));
    assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard && !bus.flush;
    assign accept = bus.in_valid && bus.in_ready;

    // Output bundle register and saturating stall counter; flush has top priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid   <= 1'b0;
            bus.reg_write   <= 1'b0;
            bus.alu_op      <= '0;
            bus.alu_src_imm <= 1'b0;
            bus.mem_read    <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.branch      <= 1'b0;
            bus.branch_ne   <= 1'b0;
            bus.illegal     <= 1'b0;
            bus.rd          <= '0;
            bus.rs1         <= '0;
            bus.rs2         <= '0;
            bus.stall_cnt   <= '0;
        end else begin
            if (bus.flush) begin
                bus.out_valid <= 1'b0;
            end else if (accept) begin
                bus.out_valid   <= 1'b1;
                bus.reg_write   <= rw_d;
                bus.alu_op      <= ALUOP_W'(op_d);
                bus.alu_src_imm <= imm_d;
                bus.mem_read    <= mr_d;
                bus.mem_write   <= mw_d;
                bus.branch      <= br_d;
                bus.branch_ne   <= bne_d;
                bus.illegal     <= !legal;
                bus.rd          <= rw_d ? rd_f : 5'd0;
                bus.rs1         <= rs1_f;
                bus.rs2         <= rs2_f;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (hazard && !bus.flush && !(&bus.stall_cnt))
                bus.stall_cnt <= bus.stall_cnt + CNT_W'(1);
        end
    end
endmodule
